// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one memory port between an instruction-fetch requester (I) and a
// load/store requester (D). Data accesses normally win, but after STARVE_MAX
// consecutive data grants issued while a fetch was waiting, the fetch is
// served next. Each access is registered onto the mem_* port, held stable
// until mem_ready, and completed with a one-cycle pulse (if_valid / d_done).
// One idle cycle (the pulse cycle) separates transactions so the requester
// can drop or renew its request before the arbiter samples again.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   if_req/if_addr           fetch request (held until if_valid) and address
//   if_rdata/if_valid        fetched word and completion pulse
//   d_req/d_we/d_addr        load/store request (held until d_done)
//   d_wdata/d_wstrb          store data and byte enables
//   d_rdata/d_done           load data and completion pulse
//   mem_req/mem_we/mem_addr  shared memory request, write enable, address
//   mem_wdata/mem_wstrb      memory write data and byte enables
//   mem_rdata/mem_ready      memory read data and completion
//   stall_if/stall_d         pipeline stalls while a request is outstanding
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    // fetch side
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_valid,
    // data side
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_done,
    // shared memory port
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ready,
    // pipeline stalls
    output logic                stall_if,
    output logic                stall_d
);

    localparam int         STRB_W     = DATA_W / 8;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GNT_I = 2'd1;
    localparam logic [1:0] S_GNT_D = 2'd2;

    logic [1:0]        state_q,      state_d;
    logic              mem_req_q,    mem_req_d;
    logic              mem_we_q,     mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q,  mem_wdata_d;
    logic [STRB_W-1:0] mem_wstrb_q,  mem_wstrb_d;
    logic [DATA_W-1:0] if_rdata_q,   if_rdata_d;
    logic              if_valid_q,   if_valid_d;
    logic [DATA_W-1:0] d_rdata_q,    d_rdata_d;
    logic              d_done_q,     d_done_d;
    logic [3:0]        starve_cnt_q, starve_cnt_d;

    logic pulse_cycle;
    logic fetch_starved;

    // The completion-pulse cycle is idle on purpose: the requester has not yet
    // had a chance to drop or renew its request.
    assign pulse_cycle   = if_valid_q | d_done_q;
    assign fetch_starved = starve_cnt_q >= STARVE_LIM;

    always_comb begin
        // NOTE: every next-state signal starts from a hold/default value so no
        // path through the case leaves one unassigned, which would infer a latch.
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        starve_cnt_d = starve_cnt_q;
        if_valid_d   = 1'b0;
        d_done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // mem_ready is deliberately not looked at here.
                if (!pulse_cycle) begin
                    if (d_req && (!if_req || !fetch_starved)) begin
                        state_d     = S_GNT_D;
                        mem_req_d   = 1'b1;
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        mem_wstrb_d = d_wstrb;
                        // Only grants that overtake a waiting fetch count.
                        if (if_req && !fetch_starved) begin
                            starve_cnt_d = starve_cnt_q + 4'd1;
                        end
                    end else if (if_req) begin
                        state_d      = S_GNT_I;
                        mem_req_d    = 1'b1;
                        mem_we_d     = 1'b0;
                        mem_addr_d   = if_addr;
                        mem_wdata_d  = '0;
                        mem_wstrb_d  = '0;
                        starve_cnt_d = 4'd0;
                    end
                end
            end

            S_GNT_I: begin
                if (mem_ready) begin
                    state_d    = S_IDLE;
                    mem_req_d  = 1'b0;
                    if_rdata_d = mem_rdata;
                    if_valid_d = 1'b1;
                end
            end

            S_GNT_D: begin
                if (mem_ready) begin
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                    // Stores leave the last loaded value in place.
                    if (!mem_we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                    d_done_d  = 1'b1;
                end
            end

            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
            if_rdata_q   <= '0;
            if_valid_q   <= 1'b0;
            d_rdata_q    <= '0;
            d_done_q     <= 1'b0;
            starve_cnt_q <= 4'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            if_rdata_q   <= if_rdata_d;
            if_valid_q   <= if_valid_d;
            d_rdata_q    <= d_rdata_d;
            d_done_q     <= d_done_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign if_rdata  = if_rdata_q;
    assign if_valid  = if_valid_q;
    assign d_rdata   = d_rdata_q;
    assign d_done    = d_done_q;

    assign stall_if  = if_req & ~if_valid_q;
    assign stall_d   = d_req & ~d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. The bench plays the memory: when it
// returns a read word it pushes the expected completion (which side pulses and
// which data it must present) onto a scoreboard queue; the entry is popped and
// compared when the completion pulse appears.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STRB_W     = DATA_W / 8;
    localparam int STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [STRB_W-1:0] d_wstrb;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              stall_if;
    logic              stall_d;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wstrb   (d_wstrb),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .stall_if  (stall_if),
        .stall_d   (stall_d)
    );

    typedef struct {
        logic        is_d;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_mis = 0;
    logic [31:0] if_rdata_m = '0;   // value if_rdata must hold
    logic [31:0] d_rdata_m  = '0;   // value d_rdata must hold

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 2 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Wait (bounded) until mem_req rises and check how many cycles it took.
    task automatic wait_grant(input string tag, input int exp_ticks);
        int n = 0;
        while (mem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, " grant latency"}, 64'(n), 64'(exp_ticks));
    endtask

    // Act as memory for the access currently on the port: check the request,
    // hold off for 'waits' cycles checking stability, then return rdata.
    task automatic serve(input string tag, input int waits, input logic [31:0] rdata,
                         input logic exp_we, input logic [31:0] exp_addr,
                         input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb,
                         input logic is_d, input logic watch_stall_d);
        exp_t e;
        check({tag, " mem_addr"},  mem_addr,  exp_addr);
        check({tag, " mem_we"},    mem_we,    exp_we);
        check({tag, " mem_wstrb"}, mem_wstrb, exp_wstrb);
        if (exp_we) check({tag, " mem_wdata"}, mem_wdata, exp_wdata);
        if (watch_stall_d) check({tag, " stall_d"}, stall_d, 1'b1);
        for (int k = 0; k < waits; k++) begin
            mem_ready = 1'b0;
            tick();
            check({tag, " wait mem_req"},  mem_req,  1'b1);
            check({tag, " wait mem_addr"}, mem_addr, exp_addr);
            check({tag, " wait pulses"},   {if_valid, d_done}, 2'b00);
            if (watch_stall_d) check({tag, " wait stall_d"}, stall_d, 1'b1);
        end
        mem_ready = 1'b1;
        mem_rdata = rdata;
        e.is_d = is_d;
        if (!is_d) begin
            if_rdata_m = rdata;
            e.data     = rdata;
        end else begin
            if (!exp_we) d_rdata_m = rdata;
            e.data = d_rdata_m;
        end
        sb_q.push_back(e);
        tick();
        mem_ready = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
    endtask

    // Called in the pulse cycle: pop the expected completion and compare.
    task automatic check_pulse(input string tag);
        exp_t e;
        check({tag, " sb depth"}, 64'(sb_q.size()), 64'd1);
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        check({tag, " if_valid"}, if_valid, !e.is_d);
        check({tag, " d_done"},   d_done,   e.is_d);
        check({tag, " mem_req"},  mem_req,  1'b0);
        if (e.is_d) begin
            check({tag, " d_rdata"},  d_rdata,  e.data);
            check({tag, " if_rdata"}, if_rdata, if_rdata_m);
            check({tag, " stall_d"},  stall_d,  1'b0);
        end else begin
            check({tag, " if_rdata"}, if_rdata, e.data);
            check({tag, " d_rdata"},  d_rdata,  d_rdata_m);
            check({tag, " stall_if"}, stall_if, 1'b0);
        end
    endtask

    // Cycle after the pulse: pulse gone, and no grant issued during the pulse cycle.
    task automatic after_pulse(input string tag);
        tick();
        check({tag, " pulses cleared"}, {if_valid, d_done}, 2'b00);
        check({tag, " idle after pulse"}, mem_req, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        d_wstrb   = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst mem_req",    mem_req,  1'b0);
        check("rst mem_we",     mem_we,   1'b0);
        check("rst mem_addr",   mem_addr, 32'h0);
        check("rst mem_wstrb",  mem_wstrb, 4'h0);
        check("rst if_valid",   if_valid, 1'b0);
        check("rst d_done",     d_done,   1'b0);
        check("rst if_rdata",   if_rdata, 32'h0);
        check("rst d_rdata",    d_rdata,  32'h0);
        check("rst starve_cnt", dut.starve_cnt_q, 4'd0);
        rst_n = 1'b1;
        tick();

        // Fetch only
        if_req  = 1'b1;
        if_addr = 32'h8;
        #1;
        check("fetch stall_if", stall_if, 1'b1);
        wait_grant("fetch", 1);
        serve("fetch", 0, 32'h00C0_0193, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0, 1'b0);
        check_pulse("fetch");
        if_req = 1'b0;
        after_pulse("fetch");

        // Simultaneous store and fetch: store first, then fetch
        if_req  = 1'b1;
        if_addr = 32'h10;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'hC;
        d_wdata = 32'h5;
        d_wstrb = 4'hF;
        wait_grant("sim store", 1);
        check("sim store starve_cnt", dut.starve_cnt_q, 4'd1);
        serve("sim store", 0, 32'h1111_1111, 1'b1, 32'hC, 32'h5, 4'hF, 1'b1, 1'b1);
        check_pulse("sim store");
        d_req = 1'b0;
        after_pulse("sim store");
        wait_grant("sim fetch", 1);
        check("sim fetch starve_cnt", dut.starve_cnt_q, 4'd0);
        serve("sim fetch", 0, 32'h0000_0013, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b0);
        check_pulse("sim fetch");
        if_req = 1'b0;
        after_pulse("sim fetch");

        // Starvation: four data grants, then the waiting fetch
        if_req  = 1'b1;
        if_addr = 32'h20;
        d_req   = 1'b1;
        d_we    = 1'b0;
        for (int i = 0; i < STARVE_MAX; i++) begin
            d_addr = 32'h100 + 32'(4 * i);
            wait_grant("starve load", 1);
            check("starve load starve_cnt", dut.starve_cnt_q, 64'(i + 1));
            serve("starve load", 0, 32'hA000_0000 + 32'(i), 1'b0, 32'h100 + 32'(4 * i),
                  32'h0, d_wstrb, 1'b1, 1'b1);
            check_pulse("starve load");
            after_pulse("starve load");
        end
        wait_grant("starve fetch", 1);
        check("starve fetch starve_cnt", dut.starve_cnt_q, 4'd0);
        serve("starve fetch", 0, 32'h0040_0093, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 1'b0);
        check_pulse("starve fetch");
        if_req = 1'b0;
        d_addr = 32'h200;
        after_pulse("starve fetch");
        wait_grant("starve tail", 1);
        check("starve tail starve_cnt", dut.starve_cnt_q, 4'd0);
        serve("starve tail", 0, 32'h5555_AAAA, 1'b0, 32'h200, 32'h0, d_wstrb, 1'b1, 1'b1);
        check_pulse("starve tail");
        d_req = 1'b0;
        after_pulse("starve tail");

        // Wait states on a load
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h40;
        wait_grant("wait load", 1);
        serve("wait load", 5, 32'hCAFE_F00D, 1'b0, 32'h40, 32'h0, d_wstrb, 1'b1, 1'b1);
        check_pulse("wait load");
        d_req = 1'b0;
        after_pulse("wait load");
        check("wait load stall_d idle", stall_d, 1'b0);

        // Fetch request dropped mid-access still completes
        if_req  = 1'b1;
        if_addr = 32'h44;
        wait_grant("drop fetch", 1);
        if_req = 1'b0;
        serve("drop fetch", 2, 32'h0010_0073, 1'b0, 32'h44, 32'h0, 4'h0, 1'b0, 1'b0);
        check_pulse("drop fetch");
        after_pulse("drop fetch");

        // Reset during a data grant
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h80;
        d_wdata = 32'h77;
        d_wstrb = 4'h3;
        wait_grant("rst mid", 1);
        #1 rst_n = 1'b0;
        #1;
        check("rst mid mem_req",    mem_req,  1'b0);
        check("rst mid mem_we",     mem_we,   1'b0);
        check("rst mid mem_addr",   mem_addr, 32'h0);
        check("rst mid if_rdata",   if_rdata, 32'h0);
        check("rst mid starve_cnt", dut.starve_cnt_q, 4'd0);
        if_rdata_m = '0;
        d_rdata_m  = '0;
        tick();
        mem_ready = 1'b1;
        tick();
        check("rst mid no d_done", d_done,  1'b0);
        check("rst mid held low",  mem_req, 1'b0);
        mem_ready = 1'b0;
        rst_n     = 1'b1;
        wait_grant("rst regrant", 1);
        serve("rst regrant", 0, 32'h9999_9999, 1'b1, 32'h80, 32'h77, 4'h3, 1'b1, 1'b1);
        check_pulse("rst regrant");
        d_req = 1'b0;
        after_pulse("rst regrant");

        // Stray mem_ready while idle
        if_rdata_m = if_rdata;
        mem_ready  = 1'b1;
        mem_rdata  = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stray mem_req",  mem_req,  1'b0);
            check("stray pulses",   {if_valid, d_done}, 2'b00);
            check("stray if_rdata", if_rdata, if_rdata_m);
            check("stray d_rdata",  d_rdata,  d_rdata_m);
        end
        mem_ready = 1'b0;
        if_req    = 1'b1;
        if_addr   = 32'h48;
        wait_grant("post stray", 1);
        serve("post stray", 1, 32'h0000_0073, 1'b0, 32'h48, 32'h0, 4'h0, 1'b0, 1'b0);
        check_pulse("post stray");
        if_req = 1'b0;
        after_pulse("post stray");

        check("scoreboard drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
